bbox_pixel_scanner: RTL and testbench

- Rasterizer stage directly downstream of the coordinate converter.
- Takes one triangle at a time: a bounding box plus three vertices, all narrowed to COORD_W-bit unsigned screen coordinates.
- Walks every pixel of the box in raster order and evaluates the three edge functions at each pixel.
- Emits each covered pixel as a fragment on a valid/ready interface toward fragment shading.

---
 rtl/bbox_pixel_scanner.sv | 193 +++++++++++++++++++
 tb/tb_bbox_pixel_scanner.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_pixel_scanner.sv
// bbox_pixel_scanner
//   Rasterizer stage that walks a triangle's bounding box in raster order,
//   evaluates the three edge functions at every pixel and emits each
//   covered pixel as a fragment.
//
// Ports
//   clk                      clock, all state updates on posedge
//   rst                      synchronous, active-low reset
//   tri_valid / tri_ready    triangle input handshake (ready only in IDLE)
//   min_x..max_y             inclusive bounding box
//   x0,y0,x1,y1,x2,y2        triangle vertices
//   frag_valid / frag_ready  fragment output handshake
//   frag_x, frag_y           covered pixel coordinate
//   tri_done                 one-cycle pulse when the scan of a triangle ends
//
// Handshakes: a transfer happens on a posedge where valid && ready are both
// high. Once frag_valid is raised, frag_valid/frag_x/frag_y hold until the
// transfer; valid never depends combinationally on ready.
module bbox_pixel_scanner #(
   parameter int COORD_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tri_valid,
   output logic               tri_ready,
   input  logic [COORD_W-1:0] min_x,
   input  logic [COORD_W-1:0] min_y,
   input  logic [COORD_W-1:0] max_x,
   input  logic [COORD_W-1:0] max_y,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] x2,
   input  logic [COORD_W-1:0] y2,
   output logic               frag_valid,
   input  logic               frag_ready,
   output logic [COORD_W-1:0] frag_x,
   output logic [COORD_W-1:0] frag_y,
   output logic               tri_done
);

   localparam int DW = COORD_W + 1;       // signed coordinate difference
   localparam int PW = 2 * COORD_W + 2;   // signed product
   localparam int SW = 2 * COORD_W + 3;   // signed edge function value

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SCAN  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;

   logic [COORD_W-1:0] box_min_x, box_min_y, box_max_x, box_max_y;
   logic [COORD_W-1:0] vx0, vy0, vx1, vy1, vx2, vy2;
   logic [COORD_W-1:0] cx, cy;
   logic signed [SW-1:0] area;

   // E_ab(px,py) = (xb-xa)*(py-ya) - (yb-ya)*(px-xa), computed at full width
   function automatic logic signed [SW-1:0] edge_fn(
      input logic [COORD_W-1:0] xa,
      input logic [COORD_W-1:0] ya,
      input logic [COORD_W-1:0] xb,
      input logic [COORD_W-1:0] yb,
      input logic [COORD_W-1:0] px,
      input logic [COORD_W-1:0] py
   );
      logic signed [DW-1:0] dx_ab, dy_ab, dx_ap, dy_ap;
      logic signed [PW-1:0] p_a, p_b;
      dx_ab = $signed({1'b0, xb}) - $signed({1'b0, xa});
      dy_ab = $signed({1'b0, yb}) - $signed({1'b0, ya});
      dx_ap = $signed({1'b0, px}) - $signed({1'b0, xa});
      dy_ap = $signed({1'b0, py}) - $signed({1'b0, ya});
      p_a   = PW'(dx_ab) * PW'(dy_ap);
      p_b   = PW'(dy_ab) * PW'(dx_ap);
      return SW'(p_a) - SW'(p_b);
   endfunction

   logic signed [SW-1:0] setup_area;
   logic signed [SW-1:0] e01, e12, e20;
   logic                 all_nonneg, all_nonpos, covered;
   logic                 step, last_x, last_pixel, empty_box;

   assign setup_area = edge_fn(vx0, vy0, vx1, vy1, vx2, vy2);
   assign e01        = edge_fn(vx0, vy0, vx1, vy1, cx, cy);
   assign e12        = edge_fn(vx1, vy1, vx2, vy2, cx, cy);
   assign e20        = edge_fn(vx2, vy2, vx0, vy0, cx, cy);

   assign all_nonneg = !e01[SW-1] && !e12[SW-1] && !e20[SW-1];
   assign all_nonpos = (e01[SW-1] || (e01 == '0)) &&
                       (e12[SW-1] || (e12 == '0)) &&
                       (e20[SW-1] || (e20 == '0));

   // E01+E12+E20 equals the area term at every pixel, so for a non-degenerate
   // triangle "all >= 0" is only reachable with positive area and "all <= 0"
   // only with negative area; selecting by the area sign accepts both
   // windings and includes edge pixels.
   assign covered    = area[SW-1] ? all_nonpos : all_nonneg;

   assign step       = !frag_valid || frag_ready;
   assign last_x     = (cx == box_max_x);
   assign last_pixel = last_x && (cy == box_max_y);
   assign empty_box  = (box_min_x > box_max_x) || (box_min_y > box_max_y);

   assign tri_ready  = rst && (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         frag_valid <= 1'b0;
         frag_x     <= '0;
         frag_y     <= '0;
         tri_done   <= 1'b0;
         box_min_x  <= '0;
         box_min_y  <= '0;
         box_max_x  <= '0;
         box_max_y  <= '0;
         vx0        <= '0;
         vy0        <= '0;
         vx1        <= '0;
         vy1        <= '0;
         vx2        <= '0;
         vy2        <= '0;
         cx         <= '0;
         cy         <= '0;
         area       <= '0;
      end else begin
         tri_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tri_valid) begin
                  box_min_x <= min_x;
                  box_min_y <= min_y;
                  box_max_x <= max_x;
                  box_max_y <= max_y;
                  vx0       <= x0;
                  vy0       <= y0;
                  vx1       <= x1;
                  vy1       <= y1;
                  vx2       <= x2;
                  vy2       <= y2;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               area <= setup_area;
               cx   <= box_min_x;
               cy   <= box_min_y;
               if ((setup_area == '0) || empty_box) begin
                  state    <= DONE;
                  tri_done <= 1'b1;
               end else begin
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (step) begin
                  frag_valid <= covered;
                  if (covered) begin
                     frag_x <= cx;
                     frag_y <= cy;
                  end
                  // Equality tests only, so a box touching the top of the
                  // coordinate range terminates without wrapping.
                  if (last_pixel) begin
                     state    <= DONE;
                     tri_done <= 1'b1;
                  end else if (last_x) begin
                     cx <= box_min_x;
                     cy <= cy + 1'b1;
                  end else begin
                     cx <= cx + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         // A fragment left pending after the scan drains here, independent
         // of whichever triangle is being set up next.
         if ((state != SCAN) && frag_valid && frag_ready) begin
            frag_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bbox_pixel_scanner.sv
// Testbench for bbox_pixel_scanner: directed scenarios plus randomized
// triangles, checked against a reference model that enumerates the box with
// plain integer edge-function arithmetic.
module tb_bbox_pixel_scanner;

   localparam int CW = 10;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic          tri_valid = 1'b0;
   logic          tri_ready;
   logic [CW-1:0] min_x = '0, min_y = '0, max_x = '0, max_y = '0;
   logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
   logic          frag_valid;
   logic          frag_ready = 1'b1;
   logic [CW-1:0] frag_x, frag_y;
   logic          tri_done;

   bbox_pixel_scanner #(.COORD_W(CW)) dut (
      .clk(clk), .rst(rst),
      .tri_valid(tri_valid), .tri_ready(tri_ready),
      .min_x(min_x), .min_y(min_y), .max_x(max_x), .max_y(max_y),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
      .frag_valid(frag_valid), .frag_ready(frag_ready),
      .frag_x(frag_x), .frag_y(frag_y),
      .tri_done(tri_done)
   );

   // ---------------- scoreboard state ----------------
   int errors = 0;
   int checks = 0;
   logic [2*CW-1:0] exp_q[$];
   logic [2*CW-1:0] got_q[$];
   int exp_off;
   int t_acc, done_cyc, rdy_cyc, stall_bad, done_pulses, timed_out;

   typedef struct {
      int mnx, mny, mxx, mxy;
      int ax, ay, bx, by, cx, cy;
   } tri_t;

   function automatic tri_t mk(int mnx, int mny, int mxx, int mxy,
                               int ax, int ay, int bx, int by, int cx, int cy);
      tri_t t;
      t.mnx = mnx; t.mny = mny; t.mxx = mxx; t.mxy = mxy;
      t.ax = ax; t.ay = ay; t.bx = bx; t.by = by; t.cx = cx; t.cy = cy;
      return t;
   endfunction

   // ---------------- reference model ----------------
   function automatic longint e_fn(int xa, int ya, int xb, int yb, int px, int py);
      return longint'(xb - xa) * longint'(py - ya) - longint'(yb - ya) * longint'(px - xa);
   endfunction

   // Fills exp_q with the covered pixels in raster order and exp_off with the
   // tri_done cycle offset from acceptance when frag_ready stays high.
   function automatic void build_expected(input tri_t t);
      longint area, a, b, c;
      exp_q.delete();
      area = e_fn(t.ax, t.ay, t.bx, t.by, t.cx, t.cy);
      if (area == 0 || t.mnx > t.mxx || t.mny > t.mxy) begin
         exp_off = 2;
         return;
      end
      exp_off = 2 + (t.mxx - t.mnx + 1) * (t.mxy - t.mny + 1);
      for (int py = t.mny; py <= t.mxy; py++) begin
         for (int px = t.mnx; px <= t.mxx; px++) begin
            a = e_fn(t.ax, t.ay, t.bx, t.by, px, py);
            b = e_fn(t.bx, t.by, t.cx, t.cy, px, py);
            c = e_fn(t.cx, t.cy, t.ax, t.ay, px, py);
            if ((a >= 0 && b >= 0 && c >= 0) || (a <= 0 && b <= 0 && c <= 0))
               exp_q.push_back({CW'(px), CW'(py)});
         end
      end
   endfunction

   // ---------------- driver ----------------
   task automatic drive_tri(input tri_t t);
      int n;
      n = 0;
      while (!tri_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      min_x = CW'(t.mnx); min_y = CW'(t.mny); max_x = CW'(t.mxx); max_y = CW'(t.mxy);
      x0 = CW'(t.ax); y0 = CW'(t.ay); x1 = CW'(t.bx); y1 = CW'(t.by);
      x2 = CW'(t.cx); y2 = CW'(t.cy);
      tri_valid = 1'b1;
      t_acc = cyc;
      @(negedge clk);
      tri_valid = 1'b0;
   endtask

   // Drives one triangle and records every accepted fragment into got_q.
   // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
   task automatic run_tri(input tri_t t, input int mode);
      logic          prev_stall;
      logic [CW-1:0] sx, sy;
      logic          finished;
      got_q.delete();
      done_cyc = -1; rdy_cyc = -1; stall_bad = 0; done_pulses = 0; timed_out = 0;
      prev_stall = 1'b0; sx = '0; sy = '0; finished = 1'b0;
      frag_ready = 1'b1;
      drive_tri(t);
      for (int k = 0; k < 600 && !finished; k++) begin
         case (mode)
            0:       frag_ready = 1'b1;
            1:       frag_ready = ((k % 4) == 0) || ((k % 4) == 3);
            default: frag_ready = 1'($urandom_range(0, 1));
         endcase
         if (prev_stall && (!frag_valid || frag_x !== sx || frag_y !== sy)) stall_bad++;
         if (tri_done) begin
            done_pulses++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc > done_cyc && tri_ready && rdy_cyc < 0) rdy_cyc = cyc;
         if (frag_valid && frag_ready) got_q.push_back({frag_x, frag_y});
         prev_stall = frag_valid && !frag_ready;
         sx = frag_x; sy = frag_y;
         if (done_cyc >= 0 && rdy_cyc >= 0 && !prev_stall) finished = 1'b1;
         else @(negedge clk);
      end
      if (!finished) timed_out = 1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (frag_valid !== 1'b0) begin errors++; $display("FAIL reset_frag_valid got=%b exp=0", frag_valid); end
      checks++; if (frag_x !== '0 || frag_y !== '0) begin errors++; $display("FAIL reset_frag_xy got=(%0d,%0d) exp=(0,0)", frag_x, frag_y); end
      checks++; if (tri_done !== 1'b0) begin errors++; $display("FAIL reset_tri_done got=%b exp=0", tri_done); end
      checks++; if (tri_ready !== 1'b0) begin errors++; $display("FAIL reset_tri_ready got=%b exp=0", tri_ready); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (tri_ready !== 1'b1) begin errors++; $display("FAIL post_reset_tri_ready got=%b exp=1", tri_ready); end
   endtask

   task automatic test_right_triangle();
      tri_t t;
      t = mk(0, 0, 3, 3, 0, 0, 3, 0, 0, 3);
      build_expected(t);
      run_tri(t, 0);
      checks++; if (timed_out != 0) begin errors++; $display("FAIL right_timeout got=%0d exp=0", timed_out); end
      checks++; if (got_q.size() != 10) begin errors++; $display("FAIL right_count got=%0d exp=10", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL right_frag[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (done_cyc - t_acc != 18) begin errors++; $display("FAIL right_done_cycle got=T+%0d exp=T+18", done_cyc - t_acc); end
      checks++; if (done_pulses != 1) begin errors++; $display("FAIL right_done_pulses got=%0d exp=1", done_pulses); end
   endtask

   task automatic test_reverse_winding();
      tri_t t;
      t = mk(0, 0, 3, 3, 0, 0, 0, 3, 3, 0);
      build_expected(t);
      run_tri(t, 0);
      checks++; if (got_q.size() != exp_q.size() || got_q.size() != 10) begin errors++; $display("FAIL reverse_count got=%0d exp=10", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reverse_frag[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (done_cyc - t_acc != exp_off) begin errors++; $display("FAIL reverse_done_cycle got=T+%0d exp=T+%0d", done_cyc - t_acc, exp_off); end
   endtask

   task automatic test_backpressure();
      tri_t t;
      t = mk(0, 0, 3, 3, 0, 0, 3, 0, 0, 3);
      build_expected(t);
      run_tri(t, 1);
      checks++; if (timed_out != 0) begin errors++; $display("FAIL bp_timeout got=%0d exp=0", timed_out); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_frag[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable got=%0d changes exp=0", stall_bad); end
      checks++; if (done_cyc - t_acc < 18) begin errors++; $display("FAIL bp_done_cycle got=T+%0d exp>=T+18", done_cyc - t_acc); end
      checks++; if (done_pulses != 1) begin errors++; $display("FAIL bp_done_pulses got=%0d exp=1", done_pulses); end
   endtask

   task automatic test_degenerate();
      tri_t t[2];
      t[0] = mk(0, 0, 3, 3, 0, 0, 1, 1, 2, 2);    // collinear vertices
      t[1] = mk(5, 0, 4, 3, 0, 0, 3, 0, 0, 3);    // min_x > max_x
      for (int i = 0; i < 2; i++) begin
         build_expected(t[i]);
         run_tri(t[i], 0);
         checks++; if (got_q.size() != 0) begin errors++; $display("FAIL degen%0d_count got=%0d exp=0", i, got_q.size()); end
         checks++; if (done_cyc - t_acc != 2) begin errors++; $display("FAIL degen%0d_done_cycle got=T+%0d exp=T+2", i, done_cyc - t_acc); end
         checks++; if (rdy_cyc - t_acc != 3) begin errors++; $display("FAIL degen%0d_ready_cycle got=T+%0d exp=T+3", i, rdy_cyc - t_acc); end
      end
   endtask

   task automatic test_max_coord();
      tri_t t;
      t = mk(1022, 1022, 1023, 1023, 1022, 1022, 1023, 1022, 1022, 1023);
      build_expected(t);
      run_tri(t, 0);
      checks++; if (timed_out != 0) begin errors++; $display("FAIL max_timeout got=%0d exp=0", timed_out); end
      checks++; if (got_q.size() != 3) begin errors++; $display("FAIL max_count got=%0d exp=3", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL max_frag[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (done_cyc - t_acc != 6) begin errors++; $display("FAIL max_done_cycle got=T+%0d exp=T+6", done_cyc - t_acc); end
   endtask

   task automatic test_reset_mid_scan();
      tri_t t;
      int   n;
      t = mk(0, 0, 3, 3, 0, 0, 3, 0, 0, 3);
      build_expected(t);
      got_q.delete();
      frag_ready = 1'b1;
      drive_tri(t);
      n = 0;
      while (got_q.size() < 3 && n < 100) begin
         if (frag_valid) got_q.push_back({frag_x, frag_y});
         if (got_q.size() < 3) @(negedge clk);
         n++;
      end
      checks++; if (got_q.size() != 3) begin errors++; $display("FAIL rst_mid_prefix_count got=%0d exp=3", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_prefix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (frag_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_frag_valid got=%b exp=0", frag_valid); end
      checks++; if (tri_done !== 1'b0) begin errors++; $display("FAIL rst_mid_tri_done got=%b exp=0", tri_done); end
      checks++; if (tri_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_tri_ready got=%b exp=0", tri_ready); end
      checks++; if (frag_x !== '0 || frag_y !== '0) begin errors++; $display("FAIL rst_mid_frag_xy got=(%0d,%0d) exp=(0,0)", frag_x, frag_y); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (tri_ready !== 1'b1 || tri_done !== 1'b0) begin errors++; $display("FAIL rst_mid_release got ready=%b done=%b exp ready=1 done=0", tri_ready, tri_done); end
      // fresh triangle away from the origin
      t = mk(2, 3, 6, 7, 2, 3, 6, 4, 3, 7);
      build_expected(t);
      run_tri(t, 0);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_mid_new_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_new_frag[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (done_cyc - t_acc != exp_off) begin errors++; $display("FAIL rst_mid_new_done got=T+%0d exp=T+%0d", done_cyc - t_acc, exp_off); end
   endtask

   task automatic test_random();
      tri_t t;
      int   base, mode, mism;
      for (int n = 0; n < 24; n++) begin
         base = ($urandom_range(0, 1) == 1) ? 1016 : 0;
         t.ax = base + $urandom_range(0, 7); t.ay = base + $urandom_range(0, 7);
         t.bx = base + $urandom_range(0, 7); t.by = base + $urandom_range(0, 7);
         t.cx = base + $urandom_range(0, 7); t.cy = base + $urandom_range(0, 7);
         if ($urandom_range(0, 3) == 0) begin
            t.mnx = base + $urandom_range(0, 7); t.mxx = base + $urandom_range(0, 7);
            t.mny = base + $urandom_range(0, 7); t.mxy = base + $urandom_range(0, 7);
         end else begin
            t.mnx = (t.ax < t.bx) ? t.ax : t.bx; t.mnx = (t.mnx < t.cx) ? t.mnx : t.cx;
            t.mny = (t.ay < t.by) ? t.ay : t.by; t.mny = (t.mny < t.cy) ? t.mny : t.cy;
            t.mxx = (t.ax > t.bx) ? t.ax : t.bx; t.mxx = (t.mxx > t.cx) ? t.mxx : t.cx;
            t.mxy = (t.ay > t.by) ? t.ay : t.by; t.mxy = (t.mxy > t.cy) ? t.mxy : t.cy;
         end
         mode = (n % 3 == 0) ? 0 : 2;
         build_expected(t);
         run_tri(t, mode);
         mism = 0;
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mism++;
         checks++;
         if (timed_out != 0 || got_q.size() != exp_q.size() || mism != 0) begin
            errors++;
            $display("FAIL rand%0d_frags got=%0d frags (%0d wrong, timeout=%0d) exp=%0d frags", n, got_q.size(), mism, timed_out, exp_q.size());
         end
         checks++; if (done_pulses != 1 || stall_bad != 0) begin errors++; $display("FAIL rand%0d_done_stall got pulses=%0d stall_changes=%0d exp 1/0", n, done_pulses, stall_bad); end
         if (mode == 0) begin
            checks++; if (done_cyc - t_acc != exp_off) begin errors++; $display("FAIL rand%0d_done_cycle got=T+%0d exp=T+%0d", n, done_cyc - t_acc, exp_off); end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_right_triangle();
      test_reverse_winding();
      test_backpressure();
      test_degenerate();
      test_max_coord();
      test_reset_mid_scan();
      test_random();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
